// File: rtl/soc_mem_pkg.sv
// Shared types and constants for the SoC memory arbiter and its helpers.
package soc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Response watchdog: counts cycles spent waiting on memory since the issue cycle.
module mem_arb_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= CW'(1);
        end else if (i_enable) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // High in the cycle whose increment would bring the count up to TIMEOUT.
    assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF)
// and load/store (LS), one transaction in flight, with a response watchdog.
module mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter  int MEM_DEPTH  = 64,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 16,
    localparam int ADDR_WIDTH = addr_width(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,

    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_err,

    output logic                  mem_req_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid_data
);

    state_t                r_state, w_state;
    logic                  r_sel, w_sel;
    logic                  r_last_gnt, w_last_gnt;
    logic                  r_if_gnt, w_if_gnt;
    logic                  r_ls_gnt, w_ls_gnt;
    logic                  r_if_rsp_valid, w_if_rsp_valid;
    logic                  r_ls_rsp_valid, w_ls_rsp_valid;
    logic [DATA_WIDTH-1:0] r_if_rdata, w_if_rdata;
    logic [DATA_WIDTH-1:0] r_ls_rdata, w_ls_rdata;
    logic                  r_if_err, w_if_err;
    logic                  r_ls_err, w_ls_err;
    logic                  r_mem_req_valid, w_mem_req_valid;
    logic                  r_mem_we, w_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;

    logic                  w_pick;
    logic                  w_tmo_clear;
    logic                  w_tmo_enable;
    logic                  w_tmo_expired;
    logic                  w_rsp_done;
    logic                  w_rsp_err;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    // Under contention the requester not served last wins.
    assign w_pick = (if_req && ls_req) ? ~r_last_gnt : (ls_req ? REQ_LS : REQ_IF);

    mem_arb_timeout #(
        .TIMEOUT  (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_expired(w_tmo_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_sel           <= REQ_IF;
            r_last_gnt      <= REQ_LS;
            r_if_gnt        <= 1'b0;
            r_ls_gnt        <= 1'b0;
            r_if_rsp_valid  <= 1'b0;
            r_ls_rsp_valid  <= 1'b0;
            r_if_rdata      <= '0;
            r_ls_rdata      <= '0;
            r_if_err        <= 1'b0;
            r_ls_err        <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            r_state         <= w_state;
            r_sel           <= w_sel;
            r_last_gnt      <= w_last_gnt;
            r_if_gnt        <= w_if_gnt;
            r_ls_gnt        <= w_ls_gnt;
            r_if_rsp_valid  <= w_if_rsp_valid;
            r_ls_rsp_valid  <= w_ls_rsp_valid;
            r_if_rdata      <= w_if_rdata;
            r_ls_rdata      <= w_ls_rdata;
            r_if_err        <= w_if_err;
            r_ls_err        <= w_ls_err;
            r_mem_req_valid <= w_mem_req_valid;
            r_mem_we        <= w_mem_we;
            r_mem_addr      <= w_mem_addr;
            r_mem_wdata     <= w_mem_wdata;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state         = r_state;
        w_sel           = r_sel;
        w_last_gnt      = r_last_gnt;
        w_if_gnt        = 1'b0;
        w_ls_gnt        = 1'b0;
        w_if_rsp_valid  = 1'b0;
        w_ls_rsp_valid  = 1'b0;
        w_if_rdata      = r_if_rdata;
        w_ls_rdata      = r_ls_rdata;
        w_if_err        = r_if_err;
        w_ls_err        = r_ls_err;
        w_mem_req_valid = 1'b0;
        w_mem_we        = r_mem_we;
        w_mem_addr      = r_mem_addr;
        w_mem_wdata     = r_mem_wdata;
        w_tmo_clear     = 1'b0;
        w_tmo_enable    = 1'b0;
        w_rsp_done      = 1'b0;
        w_rsp_err       = 1'b0;
        w_rsp_data      = '0;

        case (r_state)
            IDLE: begin
                if (if_req || ls_req) begin
                    w_state         = ISSUE;
                    w_sel           = w_pick;
                    w_last_gnt      = w_pick;
                    w_mem_req_valid = 1'b1;
                    w_mem_we        = (w_pick == REQ_LS) && ls_we;
                    w_mem_addr      = (w_pick == REQ_LS) ? ls_addr : if_addr;
                    w_mem_wdata     = (w_pick == REQ_LS) ? ls_wdata : '0;
                    w_if_gnt        = (w_pick == REQ_IF);
                    w_ls_gnt        = (w_pick == REQ_LS);
                end
            end
            ISSUE: begin
                w_tmo_clear = 1'b1;
                if (mem_valid_data) begin
                    w_rsp_done = 1'b1;
                    w_rsp_data = mem_rdata;
                end else begin
                    w_state = WAIT;
                end
            end
            WAIT: begin
                // A completion in the expiry cycle still counts as good data.
                if (mem_valid_data) begin
                    w_rsp_done = 1'b1;
                    w_rsp_data = mem_rdata;
                end else if (w_tmo_expired) begin
                    w_rsp_done = 1'b1;
                    w_rsp_err  = 1'b1;
                end else begin
                    w_tmo_enable = 1'b1;
                end
            end
            RESP: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        if (w_rsp_done) begin
            w_state = RESP;
            if (r_sel == REQ_IF) begin
                w_if_rsp_valid = 1'b1;
                w_if_rdata     = w_rsp_data;
                w_if_err       = w_rsp_err;
            end else begin
                w_ls_rsp_valid = 1'b1;
                w_ls_rdata     = w_rsp_data;
                w_ls_err       = w_rsp_err;
            end
        end
    end

    assign if_gnt        = r_if_gnt;
    assign if_rsp_valid  = r_if_rsp_valid;
    assign if_rdata      = r_if_rdata;
    assign if_err        = r_if_err;
    assign ls_gnt        = r_ls_gnt;
    assign ls_rsp_valid  = r_ls_rsp_valid;
    assign ls_rdata      = r_ls_rdata;
    assign ls_err        = r_ls_err;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized requesters and memory responder checked each
// cycle against a transaction-level timing model, plus directed literal checks.
module tb_mem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int TMO   = 16;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_rsp_valid, if_err;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rsp_valid, ls_err;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic          mem_req_valid, mem_we, mem_valid_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(
        .MEM_DEPTH     (64),
        .DATA_WIDTH    (DW),
        .TIMEOUT       (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rsp_valid  (if_rsp_valid),
        .if_rdata      (if_rdata),
        .if_err        (if_err),
        .ls_req        (ls_req),
        .ls_we         (ls_we),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_gnt        (ls_gnt),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rdata      (ls_rdata),
        .ls_err        (ls_err),
        .mem_req_valid (mem_req_valid),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_valid_data(mem_valid_data)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [DW-1:0] mem [64];

    // Stimulus knobs (percent rates, fixed memory latency or -1 for random).
    int            if_rate, ls_rate, wd_rate, stray_rate, force_lat;

    // Requester-side intent.
    logic          if_pend, ls_pend, ls_w;
    logic [AW-1:0] if_a, ls_a;
    logic [DW-1:0] ls_d;

    // Transaction-level model: who owns the memory, since when, and when the arbiter is free again.
    logic          m_busy, m_sel, m_we, m_last;
    int            m_issue, m_lat, m_idle_from;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    // Expected outputs for the coming cycle.
    logic          e_if_gnt, e_ls_gnt, e_if_rsp, e_ls_rsp, e_req, e_we, e_rsp_we, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;

    // What the DUT was actually seen doing, for directed literal checks.
    int            gq[$];
    int            last_issue, last_rsp, rsp_cnt;
    logic [DW-1:0] last_rdata, last_wdata;
    logic          last_err, last_we, last_rsp_ls;
    logic [AW-1:0] last_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_exp();
        e_if_gnt = 1'b0; e_ls_gnt = 1'b0; e_if_rsp = 1'b0; e_ls_rsp = 1'b0;
        e_req    = 1'b0; e_we     = 1'b0; e_rsp_we = 1'b0; e_err    = 1'b0;
        e_addr   = '0;   e_wdata  = '0;   e_rdata  = '0;
    endtask

    function automatic int pick_lat();
        int r;
        if (force_lat >= 0) return force_lat;
        r = int'($urandom_range(0, 9));
        if (r <= 6) return r;
        if (r == 7) return TMO - 1;
        if (r == 8) return NEVER;
        return int'($urandom_range(0, TMO - 2));
    endfunction

    task automatic compare();
        check("if_gnt", if_gnt, e_if_gnt);
        check("ls_gnt", ls_gnt, e_ls_gnt);
        check("if_rsp_valid", if_rsp_valid, e_if_rsp);
        check("ls_rsp_valid", ls_rsp_valid, e_ls_rsp);
        check("mem_req_valid", mem_req_valid, e_req);
        if (e_req) begin
            check("mem_addr", mem_addr, e_addr);
            check("mem_we", mem_we, e_we);
            if (e_we) check("mem_wdata", mem_wdata, e_wdata);
        end
        if (e_if_rsp) begin
            check("if_err", if_err, e_err);
            if (!e_rsp_we) check("if_rdata", if_rdata, e_rdata);
        end
        if (e_ls_rsp) begin
            check("ls_err", ls_err, e_err);
            if (!e_rsp_we) check("ls_rdata", ls_rdata, e_rdata);
        end
        if (if_gnt) gq.push_back(0);
        if (ls_gnt) gq.push_back(1);
        if (mem_req_valid) begin
            last_issue = cyc;
            last_addr  = mem_addr;
            last_we    = mem_we;
            last_wdata = mem_wdata;
        end
        if (if_rsp_valid || ls_rsp_valid) begin
            rsp_cnt++;
            last_rsp    = cyc;
            last_rsp_ls = ls_rsp_valid;
            last_rdata  = ls_rsp_valid ? ls_rdata : if_rdata;
            last_err    = ls_rsp_valid ? ls_err : if_err;
        end
    endtask

    task automatic drive();
        if (e_if_gnt) if_pend = 1'b0;
        if (e_ls_gnt) ls_pend = 1'b0;
        if (!if_pend) begin
            if (int'($urandom_range(0, 99)) < if_rate) begin
                if_pend = 1'b1;
                if_a    = AW'($urandom);
            end
        end else if (int'($urandom_range(0, 99)) < wd_rate) begin
            if_pend = 1'b0;
        end
        if (!ls_pend) begin
            if (int'($urandom_range(0, 99)) < ls_rate) begin
                ls_pend = 1'b1;
                ls_w    = 1'($urandom);
                ls_a    = AW'($urandom);
                ls_d    = $urandom;
            end
        end else if (int'($urandom_range(0, 99)) < wd_rate) begin
            ls_pend = 1'b0;
        end
        if_req   = if_pend;
        if_addr  = if_pend ? if_a : AW'($urandom);
        ls_req   = ls_pend;
        ls_we    = ls_pend ? ls_w : 1'($urandom);
        ls_addr  = ls_pend ? ls_a : AW'($urandom);
        ls_wdata = ls_pend ? ls_d : $urandom;
        if (m_busy && (cyc - m_issue == m_lat)) begin
            mem_valid_data = 1'b1;
            mem_rdata      = mem[m_addr];
        end else if (!m_busy && int'($urandom_range(0, 99)) < stray_rate) begin
            mem_valid_data = 1'b1;
            mem_rdata      = $urandom;
        end else begin
            mem_valid_data = 1'b0;
            mem_rdata      = $urandom;
        end
    endtask

    task automatic model_step();
        clear_exp();
        if (!m_busy) begin
            if (cyc >= m_idle_from && (if_req || ls_req)) begin
                // Round robin: on contention serve whoever was not served last.
                m_sel   = (if_req && ls_req) ? !m_last : ls_req;
                m_last  = m_sel;
                m_busy  = 1'b1;
                m_issue = cyc + 1;
                m_we    = m_sel ? ls_we : 1'b0;
                m_addr  = m_sel ? ls_addr : if_addr;
                m_wdata = ls_wdata;
                m_lat   = pick_lat();
                e_if_gnt = !m_sel;
                e_ls_gnt = m_sel;
                e_req    = 1'b1;
                e_we     = m_we;
                e_addr   = m_addr;
                e_wdata  = m_wdata;
            end
        end else if (mem_valid_data || (cyc - m_issue == TMO - 1)) begin
            m_busy      = 1'b0;
            m_idle_from = cyc + 2;
            e_err       = !mem_valid_data;
            e_rdata     = mem_valid_data ? mem_rdata : '0;
            e_rsp_we    = m_we;
            e_if_rsp    = !m_sel;
            e_ls_rsp    = m_sel;
            if (m_we && mem_valid_data) mem[m_addr] = m_wdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        compare();
        drive();
        model_step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_ls_gnt", ls_gnt, 0);
        check("rst_if_rsp_valid", if_rsp_valid, 0);
        check("rst_ls_rsp_valid", ls_rsp_valid, 0);
        check("rst_if_err", if_err, 0);
        check("rst_ls_err", ls_err, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        if_pend = 1'b0;
        ls_pend = 1'b0;
        m_busy  = 1'b0;
        m_last  = 1'b1;
        m_idle_from = 0;
        clear_exp();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check("rst_hold_mem_req_valid", mem_req_valid, 0);
        reset = 1'b1;
        drive();
        model_step();
    endtask

    task automatic wait_rsp(input string name, input int budget);
        int start;
        start = rsp_cnt;
        for (int i = 0; i < budget && rsp_cnt == start; i++) tick();
        check(name, rsp_cnt - start, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_busy || if_pend || ls_pend) && n < 200) begin
            tick();
            n++;
        end
        check("drain_bound", (m_busy || if_pend || ls_pend), 0);
        repeat (3) tick();
    endtask

    initial begin
        int start;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_valid_data = 1'b0; mem_rdata = '0;
        if_rate = 0; ls_rate = 0; wd_rate = 0; stray_rate = 0; force_lat = 1;
        if_pend = 1'b0; ls_pend = 1'b0; ls_w = 1'b0; if_a = '0; ls_a = '0; ls_d = '0;
        m_busy = 1'b0; m_sel = 1'b0; m_we = 1'b0; m_last = 1'b1;
        m_issue = 0; m_lat = 0; m_idle_from = 0; m_addr = '0; m_wdata = '0;
        last_issue = 0; last_rsp = 0; rsp_cnt = 0;
        last_rdata = '0; last_wdata = '0; last_err = 1'b0; last_we = 1'b0;
        last_rsp_ls = 1'b0; last_addr = '0;
        clear_exp();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        #2;
        do_reset();

        // IF-only read, memory answers two cycles after the strobe.
        force_lat = 2;
        mem[5] = 32'hDEADBEEF;
        if_pend = 1'b1; if_a = 6'h05;
        wait_rsp("if_read_rsp", 20);
        check("if_read_addr", last_addr, 6'h05);
        check("if_read_we", last_we, 0);
        check("if_read_src", last_rsp_ls, 0);
        check("if_read_data", last_rdata, 32'hDEADBEEF);
        check("if_read_err", last_err, 0);
        check("if_read_latency", last_rsp - last_issue, 3);

        // LS write then read back the same word.
        force_lat = 1;
        ls_pend = 1'b1; ls_w = 1'b1; ls_a = 6'h3F; ls_d = 32'h12345678;
        wait_rsp("ls_write_rsp", 20);
        check("ls_write_we", last_we, 1);
        check("ls_write_addr", last_addr, 6'h3F);
        check("ls_write_wdata", last_wdata, 32'h12345678);
        check("ls_write_src", last_rsp_ls, 1);
        ls_pend = 1'b1; ls_w = 1'b0; ls_a = 6'h3F;
        wait_rsp("ls_read_rsp", 20);
        check("ls_read_data", last_rdata, 32'h12345678);
        check("ls_read_err", last_err, 0);

        // Reset while waiting on a silent memory, then stray completions.
        force_lat = NEVER;
        if_pend = 1'b1; if_a = 6'h07;
        start = rsp_cnt;
        repeat (6) tick();
        do_reset();
        stray_rate = 100;
        repeat (6) tick();
        check("reset_no_rsp", rsp_cnt - start, 0);
        stray_rate = 0;

        // Contention right after reset: strict alternation starting with IF.
        force_lat = 1;
        gq.delete();
        if_rate = 100; ls_rate = 100;
        for (int i = 0; i < 60 && gq.size() < 4; i++) tick();
        check("contention_count", gq.size() >= 4, 1);
        if (gq.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("contention_gnt%0d", i), gq[i], i % 2);
        end
        if_rate = 0; ls_rate = 0;
        drain();

        // Timeout, then a normal transaction.
        force_lat = NEVER;
        if_pend = 1'b1; if_a = 6'h02;
        wait_rsp("tmo_rsp", 40);
        check("tmo_distance", last_rsp - last_issue, 16);
        check("tmo_err", last_err, 1);
        check("tmo_rdata", last_rdata, 0);
        force_lat = 0;
        ls_pend = 1'b1; ls_w = 1'b0; ls_a = 6'h02;
        wait_rsp("after_tmo_rsp", 20);
        check("after_tmo_err", last_err, 0);
        check("after_tmo_data", last_rdata, mem[2]);

        // Completion lands in the same cycle the watchdog expires.
        force_lat = TMO - 1;
        mem[9] = 32'hCAFEF00D;
        if_pend = 1'b1; if_a = 6'h09;
        wait_rsp("edge_rsp", 40);
        check("edge_err", last_err, 0);
        check("edge_data", last_rdata, 32'hCAFEF00D);
        check("edge_distance", last_rsp - last_issue, 16);

        // Random traffic with withdrawals and stray completions.
        force_lat = -1;
        if_rate = 35; ls_rate = 35; wd_rate = 10; stray_rate = 20;
        repeat (3000) tick();
        if_rate = 0; ls_rate = 0; wd_rate = 0; stray_rate = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
